// File: rtl/trace_capture_unit.sv
// Cycle-trace unit for the single-cycle MIPS core: timestamps retired instructions
// into a circular record buffer, with trigger, filter, cycle budget and dump strobe.
module trace_capture_unit #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int CYCLE_LIMIT = 20,
  parameter int DUMP_PERIOD = 5,
  parameter int WRAP        = 1,
  localparam int REC_W      = 16 + 3*DATA_W + 8,
  localparam int CNT_W      = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [1:0]        filter,
  input  logic              retire,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        wr_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [REC_W-1:0]  rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [15:0]       cycle_count,
  output logic              dump_pulse,
  output logic              halt,
  output logic [1:0]        state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [15:0] LIMIT = 16'(CYCLE_LIMIT);
  localparam logic [15:0] DUMP_DIV = 16'((DUMP_PERIOD == 0) ? 1 : DUMP_PERIOD);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [REC_W-1:0] rec;
  logic [15:0]      cc_next;
  logic             traced, keep, store, pop, full, write_en, limit_hit, dump_hit;

  assign state = state_q;

  always_comb begin
    rec       = {cycle_count, pc, instr, reg_write, mem_write, mem_read, wr_reg, wr_data};
    cc_next   = cycle_count + 16'd1;
    limit_hit = (CYCLE_LIMIT != 0) && (cc_next == LIMIT);
    dump_hit  = (DUMP_PERIOD != 0) && (cc_next != 16'd0) && ((cc_next % DUMP_DIV) == 16'd0);
    traced    = 1'b0;
    if (!arm && retire) begin
      if (state_q == ARMED)        traced = !trig_en || (pc == trig_pc);
      else if (state_q == CAPTURE) traced = 1'b1;
    end
    keep  = (filter == 2'b00) || (filter[0] && reg_write) ||
            (filter[1] && (mem_read || mem_write));
    store = traced && keep;
    full  = (count == FULL_CNT);
    pop   = !arm && rd_en && (count != '0);
    // A pop frees a slot in the same cycle, so a full buffer still accepts the store.
    write_en = store && (!full || pop || (WRAP != 0));
    state_d = state_q;
    if (arm)         state_d = ARMED;
    else if (traced) state_d = limit_hit ? DONE : CAPTURE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (write_en) mem[wptr] <= rec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      cycle_count <= '0;
      overflow    <= 1'b0;
      halt        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      dump_pulse  <= 1'b0;
    end else if (arm) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      cycle_count <= '0;
      overflow    <= 1'b0;
      halt        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      dump_pulse  <= 1'b0;
    end else begin
      rd_valid   <= pop;
      if (pop) rd_data <= mem[rptr];
      dump_pulse <= traced && dump_hit;
      if (traced) begin
        cycle_count <= cc_next;
        if (limit_hit) halt <= 1'b1;
      end
      if (write_en) wptr <= wptr + 1'b1;
      // An overwrite at full without a pop discards the oldest entry.
      if (pop || (write_en && full)) rptr <= rptr + 1'b1;
      if (write_en && !pop && !full) count <= count + 1'b1;
      else if (pop && !write_en)     count <= count - 1'b1;
      if (store && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/trace_capture_unit.md
# trace_capture_unit

Parametrised, synthesisable cycle-trace unit for the single-cycle MIPS core. It timestamps each retired instruction together with its PC, encoding, register writeback and memory activity, stores the records in a circular buffer, and stops after a programmable cycle budget. It provides a periodic register-dump strobe and a readout handshake. It sits beside MIPS_Processor and is fed directly from its datapath signals; benches or a debug port drain it.

## Interface
- DATA_W, 32, width of PC, instruction and writeback data
- DEPTH, 16, buffer entries (power of two, ≥2)
- CYCLE_LIMIT, 20, retire cycles traced before halting (0 = unlimited)
- DUMP_PERIOD, 5, retire cycles between dump strobes (0 = disabled)
- WRAP, 1, full-buffer policy: 1 = overwrite oldest, 0 = drop newest
- REC_W (derived), 16+3*DATA_W+8, record width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- arm  in  1  start or restart a trace session
- trig_en  in  1  1 = wait for trig_pc; 0 = start on first retire after arm
- trig_pc  in  DATA_W  trigger PC
- filter  in  2  bit0 keeps reg-write cycles; bit1 keeps mem cycles; 0 keeps all
- retire  in  1  instruction completes this cycle
- pc, instr, wr_data  in  DATA_W  core PC, instruction, register write data
- wr_reg  in  5  destination register
- reg_write, mem_read, mem_write  in  1  core control strobes
- rd_en  in  1  pop request
- rd_valid  out  1  rd_data holds a popped record
- rd_data  out  REC_W  {stamp[15:0], pc, instr, reg_write, mem_write, mem_read, wr_reg, wr_data}
- count  out  $clog2(DEPTH+1)  stored records
- overflow  out  1  sticky: a record was overwritten or dropped
- cycle_count  out  16  retire cycles traced this session
- dump_pulse  out  1  one-cycle register-dump strobe
- halt  out  1  sticky: cycle budget exhausted
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

## Operation
- Reset: state IDLE. All outputs 0. Pointers cleared.
- arm in any state:
  - Clears buffer, count, cycle_count, overflow, halt and rd_valid.
  - Next state is ARMED.
  - arm has priority over every other event in that cycle.
- ARMED → CAPTURE on a retire cycle with (!trig_en || pc==trig_pc).
  - That cycle is traced, with stamp 0.
- CAPTURE: every retire cycle is traced and increments cycle_count (16-bit, wraps).
  - Stamp = cycle_count before the increment.
- Traced cycle is stored when filter==0, or (filter[0]&reg_write), or (filter[1]&(mem_read|mem_write)).
  - Unfiltered cycles still count.
- When the incremented cycle_count equals a nonzero CYCLE_LIMIT:
  - That cycle is still traced.
  - state → DONE, halt → 1.
- DONE: no captures. Reads are still allowed. Only arm or reset leaves DONE.
- Store into a full buffer:
  - WRAP=1: overwrite oldest, advance read pointer, set overflow.
  - WRAP=0: discard the record, set overflow.
- Store and pop in the same cycle:
  - Both take effect; count is unchanged.
  - At full, this is not an overflow.
- Pop returns the oldest record first. rd_en with count==0 is ignored.
- dump_pulse is high for one cycle after cycle_count becomes a nonzero multiple of DUMP_PERIOD.

## Timing
- Records are written at the clk edge that samples retire. count reflects the write at that edge.
- Pop: rd_en sampled at edge N.
  - rd_data and rd_valid are registered at edge N, so both are visible during cycle N+1.
  - rd_valid is high exactly one cycle per accepted pop.
- halt and state=DONE assert at the same edge as the final traced cycle.
- dump_pulse asserts at the same edge as the cycle_count update. It is never high two consecutive cycles unless DUMP_PERIOD=1.
- Reset deasserting mid-session leaves the unit in IDLE. It does not restart without arm.

## Test plan
- Assert reset mid-CAPTURE with count=7 → immediately state=0, count=0, halt=0, rd_valid=0; no capture until arm.
- arm, trig_en=0, filter=0, pc=4*i for 20 retires (defaults) → halt at 20th edge, cycle_count=20, count=16, overflow=1; pops return stamps 4..19 with pc 0x10..0x4C.
- trig_en=1, trig_pc=0x20, pc stepping by 4 from 0 → state stays ARMED until pc 0x20; first record has stamp 0 and pc 0x20.
- WRAP=0, 20 retires → count=16, overflow=1; pops give stamps 0..15, then rd_en yields rd_valid=0.
- filter=01, reg_write high on odd cycles only, 20 retires → count=10 with stamps 1,3,…,19; dump_pulse seen at cycle_count 5, 10, 15, 20.
- Buffer full (16), WRAP=1, rd_en with a stored retire in the same cycle → count stays 16, overflow stays 0, popped stamp is the oldest.
